// File: rtl/bram_load_scheduler.sv
// Round-robin owner of the shared read-only BRAM port. One client at a time
// gets a burst of consecutive bytes, which come back tagged with their index.
// This is followed by a one-cycle done pulse to that client.
// RD_LAT counts cycles from an address being on bram_addr to its byte
// appearing on rd_data. That span includes the rd_data output register, so
// the BRAM itself must return dout RD_LAT-1 cycles after sampling the address.
module bram_load_scheduler #(
  parameter int N_REQ      = 4,
  parameter int W          = 8,
  parameter int ADDR_WIDTH = 15,
  parameter int LEN_W      = 16,
  parameter int RD_LAT     = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_REQ-1:0]            req,
  input  logic [N_REQ*ADDR_WIDTH-1:0] base_addr,
  input  logic [N_REQ*LEN_W-1:0]      length,
  output logic [N_REQ-1:0]            grant,
  output logic [N_REQ-1:0]            done,
  output logic                        rd_valid,
  output logic [W-1:0]                rd_data,
  output logic [LEN_W-1:0]            rd_index,
  output logic                        bram_en,
  output logic                        bram_ren,
  output logic [ADDR_WIDTH-1:0]       bram_addr,
  input  logic [W-1:0]                bram_dout
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FINISH} state_e;

  state_e                        state_q, state_d;
  logic [IDX_W-1:0]              rr_q, rr_d, gidx_q, gidx_d;
  logic [N_REQ-1:0]              grant_q, grant_d, done_q, done_d;
  logic                          en_q, en_d, ren_q, ren_d;
  logic [ADDR_WIDTH-1:0]         addr_q, addr_d;
  logic [LEN_W-1:0]              len_q, len_d;
  // One extra bit so a burst of 2^LEN_W-1 bytes still terminates cleanly.
  logic [LEN_W:0]                k_q, k_d;
  logic [RD_LAT-1:0]             vld_pipe_q;
  logic [RD_LAT-1:0][LEN_W-1:0]  idx_pipe_q;
  logic [W-1:0]                  rd_data_q;

  logic                          pick_vld;
  logic [IDX_W-1:0]              pick_idx;
  logic                          issue_vld;

  assign issue_vld = (state_q == ISSUE);

  // Round-robin pick: first requester at or above rr, wrapping. Scanning the
  // offsets downward lets the smallest offset overwrite the larger ones.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req[(int'(rr_q) + i) % N_REQ]) begin
        pick_vld = 1'b1;
        pick_idx = IDX_W'((int'(rr_q) + i) % N_REQ);
      end
    end
  end

  // Next-state and registered-output logic for the burst sequencer.
  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    gidx_d  = gidx_q;
    grant_d = grant_q;
    done_d  = '0;
    en_d    = en_q;
    ren_d   = ren_q;
    addr_d  = addr_q;
    len_d   = len_q;
    k_d     = k_q;
    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          gidx_d  = pick_idx;
          grant_d = N_REQ'(1) << pick_idx;
          len_d   = length[pick_idx*LEN_W +: LEN_W];
          addr_d  = base_addr[pick_idx*ADDR_WIDTH +: ADDR_WIDTH];
          k_d     = '0;
          if (length[pick_idx*LEN_W +: LEN_W] == '0) begin
            state_d = FINISH;
          end else begin
            state_d = ISSUE;
            en_d    = 1'b1;
            ren_d   = 1'b1;
          end
        end
      end
      ISSUE: begin
        if (k_q + 1'b1 == {1'b0, len_q}) begin
          ren_d   = 1'b0;
          state_d = DRAIN;
        end else begin
          k_d    = k_q + 1'b1;
          addr_d = addr_q + 1'b1;
        end
      end
      DRAIN: begin
        // Empty pipeline means the last byte has already left on rd_data.
        if (vld_pipe_q == '0) begin
          en_d    = 1'b0;
          state_d = FINISH;
        end
      end
      FINISH: begin
        done_d  = grant_q;
        grant_d = '0;
        en_d    = 1'b0;
        rr_d    = (gidx_q == IDX_W'(N_REQ - 1)) ? '0 : gidx_q + 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, output registers and the read-latency tag pipeline.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      rr_q       <= '0;
      gidx_q     <= '0;
      grant_q    <= '0;
      done_q     <= '0;
      en_q       <= 1'b0;
      ren_q      <= 1'b0;
      addr_q     <= '0;
      len_q      <= '0;
      k_q        <= '0;
      vld_pipe_q <= '0;
      idx_pipe_q <= '0;
      rd_data_q  <= '0;
    end else begin
      state_q       <= state_d;
      rr_q          <= rr_d;
      gidx_q        <= gidx_d;
      grant_q       <= grant_d;
      done_q        <= done_d;
      en_q          <= en_d;
      ren_q         <= ren_d;
      addr_q        <= addr_d;
      len_q         <= len_d;
      k_q           <= k_d;
      vld_pipe_q[0] <= issue_vld;
      idx_pipe_q[0] <= k_q[LEN_W-1:0];
      for (int i = 1; i < RD_LAT; i++) begin
        vld_pipe_q[i] <= vld_pipe_q[i-1];
        idx_pipe_q[i] <= idx_pipe_q[i-1];
      end
      rd_data_q <= bram_dout;
    end
  end

  assign grant     = grant_q;
  assign done      = done_q;
  assign bram_en   = en_q;
  assign bram_ren  = ren_q;
  assign bram_addr = addr_q;
  assign rd_valid  = vld_pipe_q[RD_LAT-1];
  assign rd_index  = idx_pipe_q[RD_LAT-1];
  assign rd_data   = rd_data_q;

endmodule
